// File: rtl/ss_pkg.sv
// ss_pkg: shared BCD digit type, overflow code and active-low 7-segment glyphs.
package ss_pkg;
    typedef logic [3:0] bcd_t;
    localparam bcd_t OVF_CODE = 4'hF;
    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [9:0][6:0] GLYPHS = {
        7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
        7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };
    function automatic logic [6:0] glyph(input bcd_t d);
        return d < 4'd10 ? GLYPHS[d] : d == OVF_CODE ? SEG_DASH : SEG_OFF;
    endfunction
endpackage

// File: rtl/ss_bin2bcd.sv
// ss_bin2bcd: sequential shift-add-3 converter, one bit per cycle; result register
// changes only on the completion edge so partial conversions are never exposed.
module ss_bin2bcd
    import ss_pkg::*;
#(
    parameter int BIN_W    = 16,
    parameter int N_DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [BIN_W-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output bcd_t [N_DIGITS-1:0]   digits
);
    localparam int CW = $clog2(BIN_W + 1);
    localparam logic [63:0] MAX_VAL = 64'(10 ** N_DIGITS) - 64'd1;
    logic busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, start, last;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [CW-1:0] cnt_q, cnt_d;
    bcd_t [N_DIGITS-1:0] acc_q, acc_d, adj, digits_q, digits_d;
    logic [4*N_DIGITS:0] sh;
    always_comb begin
        for (int i = 0; i < N_DIGITS; i++)
            adj[i] = acc_q[i] >= 4'd5 ? acc_q[i] + 4'd3 : acc_q[i];
        sh = {adj, bin_q[BIN_W-1]};
        start = load && !busy_q;
        last = busy_q && cnt_q == CW'(BIN_W - 1);
        busy_d = start ? 1'b1 : last ? 1'b0 : busy_q;
        done_d = last;
        bin_d = start ? value : busy_q ? bin_q << 1 : bin_q;
        acc_d = start ? '0 : busy_q ? sh[4*N_DIGITS-1:0] : acc_q;
        cnt_d = start ? '0 : busy_q ? cnt_q + CW'(1) : cnt_q;
        ovf_d = start ? 64'(value) > MAX_VAL : ovf_q;
        digits_d = !last ? digits_q : ovf_q ? {N_DIGITS{OVF_CODE}} : sh[4*N_DIGITS-1:0];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ovf_q <= 1'b0;
            bin_q <= '0;
            cnt_q <= '0;
            acc_q <= '0;
            digits_q <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            ovf_q <= ovf_d;
            bin_q <= bin_d;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            digits_q <= digits_d;
        end
    end
    assign busy = busy_q;
    assign done = done_q;
    assign digits = digits_q;
endmodule

// File: rtl/ss_scan_driver.sv
// ss_scan_driver: multiplexed 7-segment driver with BCD conversion, leading-zero
// blanking, per-digit decimal points and whole-display blinking.
module ss_scan_driver
    import ss_pkg::*;
#(
    parameter int N_DIGITS  = 8,
    parameter int BIN_W     = 16,
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 64
) (
    input  logic                CLK100MHZ,
    input  logic                rst,
    input  logic [BIN_W-1:0]    value,
    input  logic                load,
    output logic                busy,
    output logic                done,
    input  logic                blank_lz,
    input  logic                blink_en,
    input  logic [N_DIGITS-1:0] dp_mask,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [N_DIGITS-1:0] an
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
    localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
    bcd_t [N_DIGITS-1:0] disp;
    logic [PW-1:0] pre_q, pre_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [BW-1:0] blk_q, blk_d;
    logic phase_q, phase_d, dp_q, dp_d, tick, frame_end, blink_wrap, dark, zero_run;
    logic [6:0] seg_q, seg_d;
    logic [N_DIGITS-1:0] an_q, an_d, lz;
    ss_bin2bcd #(.BIN_W(BIN_W), .N_DIGITS(N_DIGITS)) u_conv (
        .clk(CLK100MHZ), .rst(rst), .load(load), .value(value),
        .busy(busy), .done(done), .digits(disp)
    );
    // outputs latch the slot for the current index, then the index moves on
    always_comb begin
        tick = pre_q == PW'(SCAN_DIV - 1);
        frame_end = tick && idx_q == IW'(N_DIGITS - 1);
        blink_wrap = frame_end && blk_q == BW'(BLINK_DIV - 1);
        pre_d = tick ? '0 : pre_q + PW'(1);
        idx_d = frame_end ? '0 : tick ? idx_q + IW'(1) : idx_q;
        blk_d = !blink_en ? '0 : blink_wrap ? '0 : frame_end ? blk_q + BW'(1) : blk_q;
        phase_d = blink_en && (phase_q ^ blink_wrap);
        zero_run = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && disp[i] == 4'd0;
            lz[i] = zero_run;
        end
        dark = blink_en && phase_q;
        an_d = !tick ? an_q : dark ? '1 : ~(N_DIGITS'(1) << idx_q);
        seg_d = !tick ? seg_q : blank_lz && idx_q != '0 && lz[idx_q] ? SEG_OFF : glyph(disp[idx_q]);
        dp_d = !tick ? dp_q : !(dp_mask[idx_q] && !dark);
    end
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
            idx_q <= '0;
            blk_q <= '0;
            phase_q <= 1'b0;
            an_q <= '1;
            seg_q <= '1;
            dp_q <= 1'b1;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
            blk_q <= blk_d;
            phase_q <= phase_d;
            an_q <= an_d;
            seg_q <= seg_d;
            dp_q <= dp_d;
        end
    end
    assign an = an_q;
    assign seg = seg_q;
    assign dp = dp_q;
endmodule

// File: tb/tb_ss_scan_driver.sv
// tb_ss_scan_driver: table of loads with expected glyphs, scoreboarded against the
// scanned outputs, plus busy-load, blink/dp and mid-conversion reset sequences.
module tb_ss_scan_driver;
    typedef struct packed {
        logic [15:0]     value;
        logic            blz;
        logic [3:0][6:0] segs;
    } vec_t;
    logic clk = 1'b0, rst = 1'b1, load = 1'b0, blank_lz = 1'b0, blink_en = 1'b0;
    logic [15:0] value = '0;
    logic [3:0] dp_mask = '0;
    logic busy, done, dp;
    logic [6:0] seg;
    logic [3:0] an;
    int checks = 0, passes = 0, bad_an = 0;
    vec_t vecs[6];
    vec_t sb[$];

    ss_scan_driver #(.N_DIGITS(4), .BIN_W(16), .SCAN_DIV(4), .BLINK_DIV(2)) dut (
        .CLK100MHZ(clk), .rst(rst), .value(value), .load(load), .busy(busy), .done(done),
        .blank_lz(blank_lz), .blink_en(blink_en), .dp_mask(dp_mask),
        .seg(seg), .dp(dp), .an(an)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (!rst && an != 4'hF && $countones(~an) != 1) bad_an++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_scan(input string name, input logic [3:0][6:0] exp);
        logic [6:0] seen[4];
        logic [3:0] sel;
        for (int k = 0; k < 4; k++) seen[k] = 'x;
        repeat (8) @(negedge clk);
        repeat (20) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                sel = 4'b0001 << k;
                if (an == ~sel) seen[k] = seg;
            end
        end
        for (int k = 0; k < 4; k++) chk($sformatf("%s seg d%0d", name, k), seen[k], exp[k]);
    endtask

    task automatic run_load(input vec_t v);
        int n = 0, nb = 0;
        vec_t e;
        @(negedge clk);
        value = v.value;
        blank_lz = v.blz;
        load = 1'b1;
        sb.push_back(v);
        do begin
            @(negedge clk);
            load = 1'b0;
            n++;
            if (busy) nb++;
        end while (!done && n < 40);
        chk($sformatf("latency %0d", v.value), n, 17);
        chk($sformatf("busy cycles %0d", v.value), nb, 16);
        @(negedge clk);
        chk($sformatf("done pulse width %0d", v.value), done, 0);
        e = sb.pop_front();
        check_scan($sformatf("load %0d", e.value), e.segs);
    endtask

    task automatic after_reset(input string name);
        int n = 0, dn = 0;
        logic got = 1'b0;
        logic [3:0] an1 = 'x;
        logic [6:0] seg1 = 'x;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) dn++;
            if (!got && an != 4'hF) begin
                got = 1'b1;
                an1 = an;
                seg1 = seg;
            end
        end
        chk({name, " first an"}, an1, 4'b1110);
        chk({name, " first seg"}, seg1, 7'b1000000);
        chk({name, " no done"}, dn, 0);
    endtask

    initial begin
        vecs[0] = '{16'd1234, 1'b0, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
        vecs[1] = '{16'd7, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000}};
        vecs[2] = '{16'd7, 1'b0, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1111000}};
        vecs[3] = '{16'd12000, 1'b0, {7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111}};
        vecs[4] = '{16'd9999, 1'b0, {7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000}};
        vecs[5] = '{16'd305, 1'b1, {7'b1111111, 7'b0110000, 7'b1000000, 7'b0010010}};
        repeat (3) @(negedge clk);
        chk("reset an", an, 4'hF);
        chk("reset seg", seg, 7'h7F);
        chk("reset dp", dp, 1);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        after_reset("power-up");

        for (int i = 0; i < 6; i++) run_load(vecs[i]);

        begin : busy_load
            int dn = 0;
            @(negedge clk);
            blank_lz = 1'b0;
            value = 16'd1234;
            load = 1'b1;
            sb.push_back(vecs[0]);
            @(negedge clk);
            load = 1'b0;
            repeat (2) @(negedge clk);
            value = 16'd5678;
            load = 1'b1;
            @(negedge clk);
            load = 1'b0;
            repeat (40) begin
                @(negedge clk);
                if (done) dn++;
            end
            chk("busy load done count", dn, 1);
            check_scan("busy load", sb.pop_front().segs);
        end

        begin : blink
            int runs[$];
            int len = 0, dpbad = 0, dpgood = 0;
            logic prev, cur;
            @(negedge clk);
            dp_mask = 4'b0100;
            blink_en = 1'b1;
            prev = an == 4'hF;
            repeat (260) begin
                @(negedge clk);
                cur = an == 4'hF;
                if (cur == prev) len++;
                else begin
                    runs.push_back(len);
                    len = 1;
                    prev = cur;
                end
                if (dp == 1'b0 && an != 4'b1011) dpbad++;
                if (dp == 1'b0 && an == 4'b1011) dpgood++;
            end
            for (int i = 1; i <= 4; i++) chk($sformatf("blink run %0d", i), i < runs.size() ? runs[i] : -1, 32);
            chk("dp outside digit2", dpbad, 0);
            chk("dp lit on digit2", dpgood > 0, 1);
            blink_en = 1'b0;
            dp_mask = '0;
        end

        begin : reset_mid
            @(negedge clk);
            value = 16'd4321;
            load = 1'b1;
            @(negedge clk);
            load = 1'b0;
            repeat (4) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            chk("mid-reset an", an, 4'hF);
            chk("mid-reset seg", seg, 7'h7F);
            chk("mid-reset dp", dp, 1);
            chk("mid-reset busy", busy, 0);
            chk("mid-reset done", done, 0);
            after_reset("mid-reset");
            check_scan("after reset", {4{7'b1000000}});
        end

        chk("an at most one low", bad_an, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
